// File: rtl/sint_block_min.sv
// Streaming signed-minimum reducer: one (min, position) result per block of COUNT accepted samples.
// Latency: O_valid rises the cycle after the COUNT-th accept; one handshake cycle follows each block.
// Backpressure: I_ready drops while a result is held; the result stays stable until O_ready.
module sint_block_min #(
    parameter int WIDTH = 3,
    parameter int COUNT = 4,
    localparam int IDX_W = (COUNT > 1) ? $clog2(COUNT) : 1
) (
    input  logic             CLK,
    input  logic             ASYNCRESETN,
    input  logic             I_valid,
    input  logic [WIDTH-1:0] I_data,
    output logic             I_ready,
    output logic             O_valid,
    output logic [WIDTH-1:0] O_min,
    output logic [IDX_W-1:0] O_idx,
    input  logic             O_ready
);

    typedef enum logic {ACCUM, HOLD} state_t;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(COUNT - 1);

    state_t           state;
    logic [IDX_W-1:0] cnt;
    logic [WIDTH-1:0] min_reg;
    logic [IDX_W-1:0] idx_reg;

    logic             take;
    logic [WIDTH-1:0] nxt_min;
    logic [IDX_W-1:0] nxt_idx;

    // Strict less-than keeps the earliest index on ties; first sample of a block always loads.
    always_comb begin
        take    = (cnt == '0) || ($signed(I_data) < $signed(min_reg));
        nxt_min = take ? I_data : min_reg;
        nxt_idx = take ? cnt : idx_reg;
    end

    assign I_ready = (state == ACCUM);

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            state   <= ACCUM;
            cnt     <= '0;
            min_reg <= '0;
            idx_reg <= '0;
            O_valid <= 1'b0;
            O_min   <= '0;
            O_idx   <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (I_valid) begin
                        min_reg <= nxt_min;
                        idx_reg <= nxt_idx;
                        if (cnt == LAST) begin
                            cnt     <= '0;
                            state   <= HOLD;
                            O_valid <= 1'b1;
                            O_min   <= nxt_min;
                            O_idx   <= nxt_idx;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (O_ready) begin
                        state   <= ACCUM;
                        O_valid <= 1'b0;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_sint_block_min.sv
// Directed bench for sint_block_min: default build (WIDTH=3, COUNT=4) plus a COUNT=1 build.
module tb_sint_block_min;

    logic       CLK = 1'b0;
    logic       ASYNCRESETN;
    logic       I_valid;
    logic [2:0] I_data;
    logic       I_ready;
    logic       O_valid;
    logic [2:0] O_min;
    logic [1:0] O_idx;
    logic       O_ready;

    logic       v1;
    logic [2:0] d1;
    logic       i_ready1;
    logic       o_valid1;
    logic [2:0] o_min1;
    logic [0:0] o_idx1;
    logic       r1;

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    sint_block_min #(.WIDTH(3), .COUNT(4)) dut (
        .CLK(CLK), .ASYNCRESETN(ASYNCRESETN),
        .I_valid(I_valid), .I_data(I_data), .I_ready(I_ready),
        .O_valid(O_valid), .O_min(O_min), .O_idx(O_idx), .O_ready(O_ready)
    );

    sint_block_min #(.WIDTH(3), .COUNT(1)) dut1 (
        .CLK(CLK), .ASYNCRESETN(ASYNCRESETN),
        .I_valid(v1), .I_data(d1), .I_ready(i_ready1),
        .O_valid(o_valid1), .O_min(o_min1), .O_idx(o_idx1), .O_ready(r1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [2:0] d);
        I_valid = 1'b1;
        I_data  = d;
        tick();
    endtask

    task automatic check_out(input string tag, input logic v, input logic [2:0] m, input logic [1:0] i);
        check({tag, "_valid"}, O_valid, v);
        check({tag, "_min"}, O_min, m);
        check({tag, "_idx"}, O_idx, i);
    endtask

    initial begin
        ASYNCRESETN = 1'b0;
        I_valid = 1'b0; I_data = '0; O_ready = 1'b0;
        v1 = 1'b0; d1 = '0; r1 = 1'b0;
        #12;
        check_out("reset", 1'b0, 3'd0, 2'd0);
        check("reset_ready", I_ready, 1'b1);
        ASYNCRESETN = 1'b1;
        #1;
        check("reset_ready_rel", I_ready, 1'b1);

        // 1: tie keeps earliest index
        O_ready = 1'b1;
        send(3'd3); send(3'b111); send(3'd2);
        check("t1_pre_valid", O_valid, 1'b0);
        send(3'b111);
        I_valid = 1'b0;
        check_out("t1", 1'b1, 3'b111, 2'd1);
        check("t1_iready_hold", I_ready, 1'b0);
        tick();
        check("t1_valid_drop", O_valid, 1'b0);
        check("t1_iready_back", I_ready, 1'b1);

        // 2: signed boundary
        send(3'd3); send(3'd0); send(3'b100); send(3'd3);
        I_valid = 1'b0;
        check_out("t2", 1'b1, 3'b100, 2'd2);
        tick();
        check("t2_valid_drop", O_valid, 1'b0);

        // 3: backpressure, I_valid held high with a value that would win if consumed
        O_ready = 1'b0;
        send(3'd0); send(3'd1); send(3'd2); send(3'd3);
        I_data = 3'b100;
        for (int k = 0; k < 3; k++) begin
            check_out("t3_hold", 1'b1, 3'd0, 2'd0);
            check("t3_iready", I_ready, 1'b0);
            tick();
        end
        check_out("t3_hold_end", 1'b1, 3'd0, 2'd0);
        I_valid = 1'b0;
        O_ready = 1'b1;
        tick();
        check("t3_valid_drop", O_valid, 1'b0);
        O_ready = 1'b0;
        send(3'd1); send(3'b110); send(3'b110); send(3'd3);
        I_valid = 1'b0;
        check_out("t3_next", 1'b1, 3'b110, 2'd1);
        O_ready = 1'b1;
        tick();
        check("t3_next_drop", O_valid, 1'b0);

        // 4: gapped input, idle cycles carry a tempting -4
        send(3'b110);
        I_valid = 1'b0; I_data = 3'b100; tick(); tick();
        send(3'd1); send(3'b101);
        I_valid = 1'b0; I_data = 3'b100; tick();
        check("t4_pre_valid", O_valid, 1'b0);
        send(3'd0);
        I_valid = 1'b0;
        check_out("t4", 1'b1, 3'b101, 2'd2);
        tick();
        check("t4_valid_drop", O_valid, 1'b0);

        // 5: reset mid-block clears outputs without a clock edge
        send(3'b100); send(3'b100);
        I_valid = 1'b0;
        #2;
        ASYNCRESETN = 1'b0;
        #1;
        check_out("t5_rst", 1'b0, 3'd0, 2'd0);
        #1;
        ASYNCRESETN = 1'b1;
        tick();
        send(3'd2); send(3'd1); send(3'd3);
        check("t5_pre_valid", O_valid, 1'b0);
        send(3'd2);
        I_valid = 1'b0;
        check_out("t5", 1'b1, 3'd1, 2'd1);

        // reset while a result is pending
        O_ready = 1'b0;
        tick();
        check("t5h_valid", O_valid, 1'b1);
        #2;
        ASYNCRESETN = 1'b0;
        #1;
        check_out("t5h_rst", 1'b0, 3'd0, 2'd0);
        check("t5h_iready", I_ready, 1'b1);
        #1;
        ASYNCRESETN = 1'b1;
        tick();
        check("t5h_after", O_valid, 1'b0);

        // 6: COUNT=1 build
        r1 = 1'b1;
        v1 = 1'b1; d1 = 3'b111;
        tick();
        check("t6a_valid", o_valid1, 1'b1);
        check("t6a_min", o_min1, 3'b111);
        check("t6a_idx", o_idx1, 1'b0);
        check("t6a_iready", i_ready1, 1'b0);
        d1 = 3'd2;
        tick();
        check("t6_gap_valid", o_valid1, 1'b0);
        check("t6_gap_iready", i_ready1, 1'b1);
        tick();
        v1 = 1'b0;
        check("t6b_valid", o_valid1, 1'b1);
        check("t6b_min", o_min1, 3'd2);
        check("t6b_idx", o_idx1, 1'b0);
        tick();
        check("t6_end_valid", o_valid1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
